s713_bist_ctrl: RTL and testbench
=================================

# s713_bist_ctrl

Built-in self-test controller for the s713 sequential benchmark core. It drives the core's 35 primary inputs from a pseudo-random pattern generator and compacts its 23 primary outputs into a multiple-input signature register (MISR). It runs the flush, run and compare phases under a start/done handshake. It sits beside the core on the core's clock and is the only driver of the core's inputs during test.

## Interface
Parameters:
- IN_W, 35, core primary-input width (G1–G36 excluding G7, ordered G1 at bit 0).
- OUT_W, 23, core primary-output width, ordered as the core output list, first at bit 0.
- N_PATTERNS, 1024, RUN cycles per test, range 1..65535.
- FLUSH_CYCLES, 19, cycles the seed vector is held before RUN, range 1..255.
- SEED, 35'h1, LFSR load value; a value of 0 is replaced by 1.
- GOLDEN, 23'h0, expected final signature.

Ports:
- CK, in, 1, clock, rising edge.
- RSTN, in, 1, asynchronous active-low reset.
- start, in, 1, level-sampled request; acted on only in IDLE or DONE.
- abort, in, 1, returns to IDLE from any state.
- core_in, out, IN_W, vector applied to core inputs.
- core_out, in, OUT_W, core outputs (combinational from core_in and core state).
- busy, out, 1, high in FLUSH and RUN.
- done, out, 1, high in DONE.
- pass, out, 1, valid when done=1: signature == GOLDEN.
- signature, out, OUT_W, MISR contents, frozen in DONE.

## Operation
- States: IDLE, FLUSH, RUN, DONE. All are registered, with asynchronous reset to IDLE.
- **IDLE**: core_in=0, busy=0, done=0, pass=0. On start=1, go to FLUSH, load the LFSR with SEED, clear the MISR and clear the counter.
- **FLUSH**: core_in=SEED. The LFSR and MISR are held. The counter increments each cycle. After FLUSH_CYCLES cycles, go to RUN with the counter cleared.
- **RUN**: core_in=LFSR. Each cycle:
  - LFSR <= {lfsr[33:0], lfsr[34]^lfsr[32]} (x^35+x^33+1).
  - MISR <= {misr[21:0], misr[22]^misr[17]} ^ core_out (x^23+x^18+1).
  - The counter increments.
  - After N_PATTERNS captures, go to DONE.
- **DONE**: core_in=0, done=1, pass=(misr==GOLDEN), and signature holds. On start=1, go to FLUSH (done drops, MISR cleared, LFSR reloaded).
- **abort**: abort=1 in any state forces IDLE next cycle. abort takes priority over start in the same cycle. An aborted run never asserts done.
- start held high: after DONE it immediately re-arms, so DONE lasts exactly one cycle.
- The counter is 16 bits and must not wrap inside a phase. Terminal compares are counter==N-1 (RUN) and counter==F-1 (FLUSH).
- Reset is allowed mid-run. Deassertion of RSTN takes effect on the next CK edge, in IDLE with the MISR cleared.

## Timing
- Reset values: core_in=0, busy=0, done=0, pass=0, signature=0.
- All outputs are registered or decoded from state and registered datapath only. core_out is sampled only at the CK edge ending each RUN cycle.
- start sampled at edge k gives:
  - busy=1 from k+1 through k+FLUSH_CYCLES+N_PATTERNS;
  - done=1 from edge k+1+FLUSH_CYCLES+N_PATTERNS.
- core_in changes only on CK edges, so the core sees a stable vector for a full cycle.
- Vector i of RUN (i=0..N-1) equals SEED advanced i times.

## Structure
- Package s713_bist_pkg holds:
  - IN_W and OUT_W defaults;
  - the LFSR tap constants (35: bits 34,32) and MISR tap constants (23: bits 22,17);
  - the state enum {IDLE, FLUSH, RUN, DONE}.
- Sub-module bist_lfsr is parameterized by width, tap mask and MISR-mode enable. It is instantiated twice: as the generator (parallel input tied 0) and as the compactor.
- The FSM and counter live in s713_bist_ctrl.

## Test plan
- Reset: with RSTN low mid-RUN, all outputs are 0 asynchronously. After release with start=0, the block stays in IDLE for 10 cycles.
- FLUSH_CYCLES=2, N_PATTERNS=4, SEED=1, start pulsed at edge 0:
  - core_in = 1,1,1,2,4,8 on cycles 1–6;
  - done rises at edge 7.
- Same configuration with core_out tied 23'h1:
  - signature = 23'h0F after 4 captures;
  - pass=1 when GOLDEN=23'h0F, pass=0 when GOLDEN=23'h0E.
- abort asserted together with start in RUN cycle 2 → IDLE next cycle, busy=0, done never asserts. A new start then gives the full unmodified sequence.
- start held high continuously → done is a one-cycle pulse every FLUSH+N+1 cycles, and the signature is identical on each run.
- Connect the real s713 core, N_PATTERNS=1024, SEED=35'h1 → signature matches the gate-level reference model value, and a stuck-at-0 injected on core output G92 changes the signature.

Source files
------------

// File: rtl/s713_bist_pkg.sv
// rtl/s713_bist_pkg.sv - shared widths, polynomial taps and FSM states for the s713 BIST controller
package s713_bist_pkg;
  localparam int S713_IN_W  = 35;
  localparam int S713_OUT_W = 23;

  // Generator x^35+x^33+1 feeds back bits 34,32; compactor x^23+x^18+1 feeds back bits 22,17
  localparam logic [S713_IN_W-1:0]  LFSR_TAPS = (35'd1 << 34) | (35'd1 << 32);
  localparam logic [S713_OUT_W-1:0] MISR_TAPS = (23'd1 << 22) | (23'd1 << 17);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/s713_bist_ctrl_lfsr.sv
// rtl/s713_bist_ctrl_lfsr.sv - shift-left Fibonacci LFSR, optionally folding a parallel word in (MISR)
module bist_lfsr #(
  parameter int             W       = 35,
  parameter logic [W-1:0]   TAPS    = '0,
  parameter bit             MISR_EN = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_shift,
  input  logic [W-1:0] i_par,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;
  logic [W-1:0] w_step;

  assign w_step = {r_q[W-2:0], ^(r_q & TAPS)} ^ (i_par & {W{MISR_EN}});

  // load beats shift so a restart never picks up a stale step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_q <= '0;
    else if (i_load)  r_q <= i_load_val;
    else if (i_shift) r_q <= w_step;
  end

  assign o_q = r_q;
endmodule

// File: rtl/s713_bist_ctrl.sv
// rtl/s713_bist_ctrl.sv - BIST sequencer: flush, pseudo-random run and MISR compare for the s713 core
module s713_bist_ctrl
  import s713_bist_pkg::*;
#(
  parameter int               IN_W         = S713_IN_W,
  parameter int               OUT_W        = S713_OUT_W,
  parameter int               N_PATTERNS   = 1024,
  parameter int               FLUSH_CYCLES = 19,
  parameter logic [IN_W-1:0]  SEED         = 35'h1,
  parameter logic [OUT_W-1:0] GOLDEN       = 23'h0
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);
  localparam logic [IN_W-1:0] SEED_EFF  = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [15:0]     FLUSH_END = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0]     RUN_END   = 16'(N_PATTERNS - 1);

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_cnt;
  logic             w_enter_flush;
  logic             w_run;
  logic [IN_W-1:0]  w_lfsr;
  logic [OUT_W-1:0] w_misr;

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start)              w_next = FLUSH;
        FLUSH:   if (r_cnt == FLUSH_END) w_next = RUN;
        RUN:     if (r_cnt == RUN_END)   w_next = DONE;
        DONE:    if (start)              w_next = FLUSH;
        default:                         w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    pass    = 1'b0;
    core_in = '0;
    case (r_state)
      FLUSH, RUN: begin
        busy    = 1'b1;
        core_in = w_lfsr;
      end
      DONE: begin
        done = 1'b1;
        pass = (w_misr == GOLDEN);
      end
      default: ;
    endcase
  end

  // every phase change restarts the count, so it never spans phases
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN)                  r_cnt <= '0;
    else if (w_next != r_state) r_cnt <= '0;
    else if (busy)              r_cnt <= r_cnt + 16'd1;
  end

  assign w_enter_flush = (w_next == FLUSH) && (r_state != FLUSH);
  assign w_run         = (r_state == RUN);

  // the generator holds SEED through FLUSH, so it also supplies the flush vector
  bist_lfsr #(.W(IN_W), .TAPS(IN_W'(LFSR_TAPS)), .MISR_EN(1'b0)) u_gen (
    .clk        (CK),
    .rst_n      (RSTN),
    .i_load     (w_enter_flush),
    .i_load_val (SEED_EFF),
    .i_shift    (w_run),
    .i_par      ('0),
    .o_q        (w_lfsr)
  );

  bist_lfsr #(.W(OUT_W), .TAPS(OUT_W'(MISR_TAPS)), .MISR_EN(1'b1)) u_misr (
    .clk        (CK),
    .rst_n      (RSTN),
    .i_load     (w_enter_flush || abort),
    .i_load_val ('0),
    .i_shift    (w_run),
    .i_par      (core_out),
    .o_q        (w_misr)
  );

  assign signature = w_misr;
endmodule

// File: tb/tb_s713_bist_ctrl.sv
// tb/tb_s713_bist_ctrl.sv - self-checking bench for s713_bist_ctrl
module tb_s713_bist_ctrl;
  localparam int          C_F    = 3;
  localparam int          C_N    = 40;
  localparam logic [34:0] C_SEED = 35'h5_1234_5679;
  localparam logic [22:0] C_GOLD = 23'h0;

  logic        ck = 1'b0;
  logic        rstn;
  logic        start;
  logic        abort;
  logic [22:0] core_out;

  logic [34:0] a_ci, b_ci, c_ci;
  logic        a_busy, b_busy, c_busy;
  logic        a_done, b_done, c_done;
  logic        a_pass, b_pass, c_pass;
  logic [22:0] a_sig, b_sig, c_sig;

  int n_vec = 0;
  int n_bad = 0;

  always #5 ck = ~ck;

  s713_bist_ctrl #(.N_PATTERNS(4), .FLUSH_CYCLES(2), .SEED(35'h1), .GOLDEN(23'h0F)) u_dut_a (
    .CK(ck), .RSTN(rstn), .start(start), .abort(abort), .core_in(a_ci), .core_out(core_out),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig));

  s713_bist_ctrl #(.N_PATTERNS(4), .FLUSH_CYCLES(2), .SEED(35'h0), .GOLDEN(23'h0E)) u_dut_b (
    .CK(ck), .RSTN(rstn), .start(start), .abort(abort), .core_in(b_ci), .core_out(core_out),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig));

  s713_bist_ctrl #(.N_PATTERNS(C_N), .FLUSH_CYCLES(C_F), .SEED(C_SEED), .GOLDEN(C_GOLD)) u_dut_c (
    .CK(ck), .RSTN(rstn), .start(start), .abort(abort), .core_in(c_ci), .core_out(core_out),
    .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig));

  typedef struct {
    logic        start;
    logic [34:0] core_in;
    logic        busy;
    logic        done;
    logic [22:0] sig;
    logic        pass;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic run_table(input string tag);
    core_out = 23'h1;
    abort    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      start = tbl[i].start;
      tick();
      chk($sformatf("%s[%0d] a.core_in", tag, i), 64'(a_ci), 64'(tbl[i].core_in));
      chk($sformatf("%s[%0d] a.busy", tag, i), 64'(a_busy), 64'(tbl[i].busy));
      chk($sformatf("%s[%0d] a.done", tag, i), 64'(a_done), 64'(tbl[i].done));
      chk($sformatf("%s[%0d] a.sig", tag, i), 64'(a_sig), 64'(tbl[i].sig));
      chk($sformatf("%s[%0d] a.pass", tag, i), 64'(a_pass), 64'(tbl[i].pass));
      chk($sformatf("%s[%0d] b.core_in", tag, i), 64'(b_ci), 64'(tbl[i].core_in));
      chk($sformatf("%s[%0d] b.pass", tag, i), 64'(b_pass),
          64'(tbl[i].done && (tbl[i].sig == 23'h0E)));
    end
  endtask

  // reference model for DUT c: position within a test and the polynomial states
  int          m_pos;
  logic [22:0] m_misr;
  logic [34:0] m_lfsr;

  function automatic logic [34:0] lstep(input logic [34:0] v);
    return {v[33:0], v[34] ^ v[32]};
  endfunction

  task automatic model_edge(input logic s, input logic a, input logic [22:0] co);
    if (a) begin
      m_pos  = -1;
      m_misr = '0;
    end else if (m_pos < 0 || m_pos == C_F + C_N) begin
      if (s) begin
        m_pos  = 0;
        m_misr = '0;
        m_lfsr = C_SEED;
      end
    end else begin
      if (m_pos >= C_F) begin
        m_misr = {m_misr[21:0], m_misr[22] ^ m_misr[17]} ^ co;
        m_lfsr = lstep(m_lfsr);
      end
      m_pos++;
    end
  endtask

  initial begin
    logic        s, a;
    logic [22:0] co;
    logic        m_busy, m_done;
    logic [34:0] m_ci;

    tbl[0] = '{1'b1, 35'h1, 1'b1, 1'b0, 23'h0,  1'b0};
    tbl[1] = '{1'b0, 35'h1, 1'b1, 1'b0, 23'h0,  1'b0};
    tbl[2] = '{1'b0, 35'h1, 1'b1, 1'b0, 23'h0,  1'b0};
    tbl[3] = '{1'b0, 35'h2, 1'b1, 1'b0, 23'h1,  1'b0};
    tbl[4] = '{1'b0, 35'h4, 1'b1, 1'b0, 23'h3,  1'b0};
    tbl[5] = '{1'b0, 35'h8, 1'b1, 1'b0, 23'h7,  1'b0};
    tbl[6] = '{1'b0, 35'h0, 1'b0, 1'b1, 23'h0F, 1'b1};
    tbl[7] = '{1'b0, 35'h0, 1'b0, 1'b1, 23'h0F, 1'b1};

    rstn = 1'b0; start = 1'b0; abort = 1'b0; core_out = '0;
    #12;
    chk("reset core_in", 64'(a_ci), 64'h0);
    chk("reset busy", 64'(a_busy), 64'h0);
    chk("reset done", 64'(a_done), 64'h0);
    chk("reset pass", 64'(a_pass), 64'h0);
    chk("reset sig", 64'(a_sig), 64'h0);
    rstn = 1'b1;
    tick();

    run_table("seq");

    // abort together with start in RUN cycle 2
    start = 1'b1; tick();
    start = 1'b0; tick(); tick(); tick();
    chk("pre-abort busy", 64'(a_busy), 64'h1);
    start = 1'b1; abort = 1'b1; tick();
    chk("abort busy", 64'(a_busy), 64'h0);
    chk("abort core_in", 64'(a_ci), 64'h0);
    chk("abort done", 64'(a_done), 64'h0);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post-abort[%0d] done", i), 64'(a_done), 64'h0);
    end
    run_table("rerun");

    // start held high: one-cycle done pulse every F+N+1 cycles, same signature
    start = 1'b1; abort = 1'b1; tick();
    abort = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      chk($sformatf("held[%0d] done", c), 64'(a_done), 64'((c % 7) == 0));
      if ((c % 7) == 0) chk($sformatf("held[%0d] sig", c), 64'(a_sig), 64'h0F);
    end

    // asynchronous reset mid-RUN
    start = 1'b0; abort = 1'b1; tick();
    abort = 1'b0; start = 1'b1; tick();
    start = 1'b0; tick(); tick(); tick();
    #2 rstn = 1'b0;
    #1;
    chk("async rst busy", 64'(a_busy), 64'h0);
    chk("async rst core_in", 64'(a_ci), 64'h0);
    chk("async rst sig", 64'(a_sig), 64'h0);
    chk("async rst done", 64'(a_done), 64'h0);
    @(posedge ck);
    #3 rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle[%0d] busy", i), 64'(a_busy), 64'h0);
      chk($sformatf("idle[%0d] done", i), 64'(a_done), 64'h0);
      chk($sformatf("idle[%0d] core_in", i), 64'(a_ci), 64'h0);
    end

    // randomized run on DUT c against the model
    m_pos = -1; m_misr = '0; m_lfsr = '0;
    for (int i = 0; i < 3000; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 199) == 0);
      co = 23'($urandom);
      start = s; abort = a; core_out = co;
      tick();
      model_edge(s, a, co);
      m_busy = (m_pos >= 0) && (m_pos < C_F + C_N);
      m_done = (m_pos == C_F + C_N);
      m_ci   = (m_pos >= 0 && m_pos < C_F) ? C_SEED : (m_busy ? m_lfsr : 35'h0);
      chk($sformatf("rnd[%0d] core_in", i), 64'(c_ci), 64'(m_ci));
      chk($sformatf("rnd[%0d] busy", i), 64'(c_busy), 64'(m_busy));
      chk($sformatf("rnd[%0d] done", i), 64'(c_done), 64'(m_done));
      chk($sformatf("rnd[%0d] pass", i), 64'(c_pass), 64'(m_done && (m_misr == C_GOLD)));
      if (m_pos >= 0) chk($sformatf("rnd[%0d] sig", i), 64'(c_sig), 64'(m_misr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
